pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, taken-branch
// flushes and fixed-length multiply/divide freezes, plus a stall-cycle counter.
module pipeline_stall_controller #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ifIdRs,
    input  logic [4:0]  ifIdRt,
    input  logic        ifIdUsesRt,
    input  logic        idExMemRead,
    input  logic [4:0]  idExRt,
    input  logic        branchTaken,
    input  logic        mdStart,
    input  logic        mdIsDiv,
    input  logic        statClear,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        idExHold,
    output logic        exMemFlush,
    output logic        mdBusy,
    output logic [15:0] stallCycles
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;
    // The mdStart cycle is the first freeze cycle, so the counter covers the remaining N-1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_md_count;
    logic [CNT_W-1:0]    w_md_count_nxt;
    logic [STAT_W-1:0]   r_stall_cycles;
    logic                w_load_use;

    assign w_load_use = idExMemRead && (idExRt != 5'd0) &&
                        ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= RUN;
            r_md_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_md_count <= w_md_count_nxt;
        end
    end

    // Next state and control outputs; reset forces the defaults.
    always_comb begin
        w_state_nxt    = r_state;
        w_md_count_nxt = r_md_count;
        pcWrite        = 1'b1;
        ifIdWrite      = 1'b1;
        ifIdFlush      = 1'b0;
        idExFlush      = 1'b0;
        idExHold       = 1'b0;
        exMemFlush     = 1'b0;
        mdBusy         = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    if (branchTaken) begin
                        ifIdFlush = 1'b1;
                        idExFlush = 1'b1;
                    end else if (mdStart) begin
                        pcWrite        = 1'b0;
                        ifIdWrite      = 1'b0;
                        idExHold       = 1'b1;
                        exMemFlush     = 1'b1;
                        w_md_count_nxt = mdIsDiv ? DIV_LOAD : MUL_LOAD;
                        w_state_nxt    = MD_WAIT;
                    end else if (w_load_use) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExFlush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pcWrite        = 1'b0;
                    ifIdWrite      = 1'b0;
                    idExHold       = 1'b1;
                    exMemFlush     = 1'b1;
                    mdBusy         = 1'b1;
                    w_md_count_nxt = r_md_count - CNT_W'(1);
                    if (r_md_count == CNT_W'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Saturating count of frozen-PC cycles; clear wins over increment.
    always_ff @(posedge clock) begin
        if (reset || statClear) begin
            r_stall_cycles <= '0;
        end else if (!pcWrite && (r_stall_cycles != {STAT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + STAT_W'(1);
        end
    end

    assign stallCycles = reset ? '0 : r_stall_cycles;

endmodule
